uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares one UART transmitter between N_REQ requesters, typically push-buttons already reduced to one-cycle rising-edge pulses. Each pulse latches a pending request and its data byte. A round-robin arbiter picks one pending request at a time and presents it on a valid/ready handshake to the UART TX. The block sits between the button edge detectors and the UART TX core.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 8, width of each request byte

Ports:
clk_i  input  1  system clock, all logic on rising edge
rst_i  input  1  synchronous active-high reset
req_pulse_i  input  N_REQ  one-cycle request pulse per requester
req_data_i  input  N_REQ*DATA_W  byte per requester; slice k is bits [k*DATA_W +: DATA_W]
ovf_clr_i  input  1  clears all overflow flags
tx_ready_i  input  1  UART TX accepts byte when high together with tx_valid_o
tx_valid_o  output  1  byte on tx_data_o is valid
tx_data_o  output  DATA_W  byte to transmit
grant_o  output  N_REQ  one-hot requester currently being served (SEND state only)
pending_o  output  N_REQ  pending request flags
overflow_o  output  N_REQ  sticky: pulse arrived while that requester was already pending

Behaviour:
- Reset: synchronous, active-high. Applies on any clock edge where rst_i=1, including mid-SEND. Clears tx_valid_o, tx_data_o, grant_o, pending_o, overflow_o, data registers and the round-robin pointer (ptr=0). FSM goes to IDLE. Any in-flight byte is dropped.
- Capture: req_pulse_i[k]=1 with pending[k]=0 sets pending[k] and latches slice k into data_reg[k] on the same edge.
- Pulse with pending[k]=1 and no handshake on k that cycle:
  - overflow[k] <= 1.
  - The new pulse is discarded; data_reg[k] is unchanged.
- Pulse on k in the same cycle as the handshake completing k: the old request is consumed. pending[k] stays 1 with the new data, and no overflow is flagged.
- ovf_clr_i=1 clears all overflow flags. If ovf_clr_i and a new overflow event occur in the same cycle, the overflow is set (set wins).
- FSM IDLE:
  - tx_valid_o=0, grant_o=0.
  - If any pending bit is set, the winner is the first set bit scanning ptr, ptr+1, ... modulo N_REQ.
  - Next edge: tx_data_o<=data_reg[winner], grant_o<=onehot(winner), tx_valid_o<=1, state -> SEND.
  - Latency: 1 cycle from a pending bit being visible to tx_valid_o=1. A pulse at edge t gives tx_valid_o=1 after edge t+1.
- FSM SEND:
  - tx_valid_o, tx_data_o and grant_o are held stable until the handshake (tx_ready_i=1).
  - On handshake:
    - pending[winner] <= 0, unless a new pulse arrives on it that cycle.
    - ptr <= (winner+1) mod N_REQ.
    - tx_valid_o<=0, grant_o<=0, state -> IDLE.
- Throughput: at most one byte per 2 cycles. tx_valid_o always drops for at least one cycle between bytes.
- Requests arriving during SEND never preempt the current grant.
- pending_o reflects the registered flags directly.

Optional Feature:
Macro UART_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest index pending requester always wins; ptr is unused and held at 0.
- Undefined (default): round-robin as described above.
- All other behaviour is identical in both modes.

Test Plan:
- Single request: rst then pulse req 2 with data 0x41, tx_ready_i=1 -> tx_valid_o high one edge later with tx_data_o=0x41 and grant_o=0100; next cycle valid=0 and pending_o=0.
- Backpressure: pulse req 0 with 0x55, tx_ready_i=0 for 5 cycles then 1 -> tx_valid_o and tx_data_o=0x55 stable all 6 cycles; a single handshake follows.
- Round-robin: pulse reqs 0,1,3 together with data 0x10, 0x11, 0x13, tx_ready_i=1 -> output order 0x10, 0x11, 0x13, then ptr=0. A second burst of reqs 0 and 3 after serving req 3 gives order 0x10 then 0x13 (ptr wraps to 0).
- Fixed-priority build: same stimulus with UART_ARB_FIXED_PRIO_EN defined -> the second burst gives order 0x10 then 0x13. Any later req 0 always beats req 3.
- Overflow: pulse req 1 with 0x22 while tx_ready_i=0 and req 0 is in SEND, then pulse req 1 with 0x33 -> overflow_o=0010, and 0x22 is sent for req 1. ovf_clr_i pulse -> overflow_o=0.
- Simultaneous and reset:
  - Pulse req 0 with 0x77 in the cycle req 0 handshakes -> pending_o[0]=1 and 0x77 is sent next with no overflow.
  - rst_i=1 mid-SEND -> next edge all outputs 0 and the held byte is never sent.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX between N_REQ pulse requesters.
// Define UART_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, ptr held at 0).
module uart_tx_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [N_REQ-1:0]          req_pulse_i,
    input  logic [N_REQ*DATA_W-1:0]   req_data_i,
    input  logic                      ovf_clr_i,
    input  logic                      tx_ready_i,
    output logic                      tx_valid_o,
    output logic [DATA_W-1:0]         tx_data_o,
    output logic [N_REQ-1:0]          grant_o,
    output logic [N_REQ-1:0]          pending_o,
    output logic [N_REQ-1:0]          overflow_o
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              state_r;
    logic [N_REQ-1:0]    pending_r;
    logic [N_REQ-1:0]    overflow_r;
    logic [DATA_W-1:0]   data_r [N_REQ];
    logic [IDX_W-1:0]    ptr_r;
    logic [IDX_W-1:0]    winner_r;
    logic [IDX_W-1:0]    pick_s;
    logic                any_s;
    logic                hs_s;
    logic [N_REQ-1:0]    done_s;
    logic [N_REQ-1:0]    capture_s;
    logic [N_REQ-1:0]    ovf_evt_s;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Winner selection; scanning downward lets the first match in priority order land last.
    always_comb begin
        int idx_v;
        pick_s = '0;
        any_s  = 1'b0;
        idx_v  = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
`ifdef UART_ARB_FIXED_PRIO_EN
            idx_v = i;
`else
            idx_v = int'(ptr_r) + i;
            if (idx_v >= N_REQ) begin
                idx_v = idx_v - N_REQ;
            end else begin
                idx_v = idx_v;
            end
`endif
            if (pending_r[idx_v]) begin
                pick_s = IDX_W'(idx_v);
                any_s  = 1'b1;
            end else begin
                pick_s = pick_s;
            end
        end
    end

    assign hs_s      = (state_r == SEND) && tx_ready_i;
    assign done_s    = hs_s ? onehot(winner_r) : '0;
    // A pulse landing on the request being consumed this cycle re-arms it instead of overflowing.
    assign capture_s = req_pulse_i & (~pending_r | done_s);
    assign ovf_evt_s = req_pulse_i & pending_r & ~done_s;

    assign pending_o  = pending_r;
    assign overflow_o = overflow_r;

    // Pending flags, latched bytes and sticky overflow flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_r  <= '0;
            overflow_r <= '0;
            for (int k = 0; k < N_REQ; k++) begin
                data_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                if (capture_s[k]) begin
                    data_r[k] <= req_data_i[k*DATA_W +: DATA_W];
                end
            end
            pending_r  <= (pending_r & ~done_s) | capture_s;
            overflow_r <= (ovf_clr_i ? '0 : overflow_r) | ovf_evt_s;
        end
    end

    // Grant FSM driving the registered valid/ready handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= IDLE;
            tx_valid_o <= 1'b0;
            tx_data_o  <= '0;
            grant_o    <= '0;
            winner_r   <= '0;
            ptr_r      <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_s) begin
                        tx_data_o  <= data_r[pick_s];
                        grant_o    <= onehot(pick_s);
                        winner_r   <= pick_s;
                        tx_valid_o <= 1'b1;
                        state_r    <= SEND;
                    end
                end
                SEND: begin
                    if (tx_ready_i) begin
                        tx_valid_o <= 1'b0;
                        grant_o    <= '0;
                        state_r    <= IDLE;
`ifdef UART_ARB_FIXED_PRIO_EN
                        ptr_r      <= '0;
`else
                        if (winner_r == IDX_W'(N_REQ - 1)) begin
                            ptr_r <= '0;
                        end else begin
                            ptr_r <= winner_r + IDX_W'(1);
                        end
`endif
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    tx_valid_o <= 1'b0;
                    grant_o    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (N_REQ=4, DATA_W=8).
// Expected round-robin vs fixed-priority order follows UART_ARB_FIXED_PRIO_EN.
module tb_uart_tx_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  req_pulse_i;
    logic [31:0] req_data_i;
    logic        ovf_clr_i;
    logic        tx_ready_i;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic [3:0]  grant_o;
    logic [3:0]  pending_o;
    logic [3:0]  overflow_o;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    int hs_base;

    uart_tx_arbiter #(.N_REQ(4), .DATA_W(8)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_pulse_i(req_pulse_i),
        .req_data_i (req_data_i),
        .ovf_clr_i  (ovf_clr_i),
        .tx_ready_i (tx_ready_i),
        .tx_valid_o (tx_valid_o),
        .tx_data_o  (tx_data_o),
        .grant_o    (grant_o),
        .pending_o  (pending_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    // Count completed handshakes independently of the checks.
    always @(posedge clk_i) begin
        if (!rst_i && tx_valid_o && tx_ready_i) hs_cnt <= hs_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Wait (bounded) for a valid byte, check it, then let the handshake happen (tx_ready_i=1).
    task automatic expect_tx(input string tag, input logic [7:0] exp_data, input logic [3:0] exp_grant);
        int n;
        n = 0;
        while (!tx_valid_o && n < 8) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, {31'd0, tx_valid_o}, 32'd1);
        check({tag, "_data"}, {24'd0, tx_data_o}, {24'd0, exp_data});
        check({tag, "_grant"}, {28'd0, grant_o}, {28'd0, exp_grant});
        tick();
        check({tag, "_drop"}, {31'd0, tx_valid_o}, 32'd0);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i       = 1'b1;
        req_pulse_i = 4'b0000;
        req_data_i  = 32'd0;
        ovf_clr_i   = 1'b0;
        tx_ready_i  = 1'b0;
        do_reset();
        check("rst_valid", {31'd0, tx_valid_o}, 32'd0);
        check("rst_pending", {28'd0, pending_o}, 32'd0);
        check("rst_overflow", {28'd0, overflow_o}, 32'd0);
        check("rst_grant", {28'd0, grant_o}, 32'd0);

        // Single request: req 2, 0x41
        tx_ready_i      = 1'b1;
        req_pulse_i     = 4'b0100;
        req_data_i[23:16] = 8'h41;
        tick();
        req_pulse_i = 4'b0000;
        check("single_pending", {28'd0, pending_o}, 32'h4);
        check("single_valid_early", {31'd0, tx_valid_o}, 32'd0);
        tick();
        check("single_valid", {31'd0, tx_valid_o}, 32'd1);
        check("single_data", {24'd0, tx_data_o}, 32'h41);
        check("single_grant", {28'd0, grant_o}, 32'h4);
        tick();
        check("single_drop", {31'd0, tx_valid_o}, 32'd0);
        check("single_pend_clr", {28'd0, pending_o}, 32'd0);

        // Backpressure: req 0, 0x55, ready low 5 cycles
        tx_ready_i      = 1'b0;
        req_pulse_i     = 4'b0001;
        req_data_i[7:0] = 8'h55;
        tick();
        req_pulse_i = 4'b0000;
        tick();
        hs_base = hs_cnt;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {31'd0, tx_valid_o}, 32'd1);
            check("bp_data", {24'd0, tx_data_o}, 32'h55);
            tick();
        end
        tx_ready_i = 1'b1;
        check("bp_valid6", {31'd0, tx_valid_o}, 32'd1);
        check("bp_data6", {24'd0, tx_data_o}, 32'h55);
        tick();
        check("bp_drop", {31'd0, tx_valid_o}, 32'd0);
        tick();
        check("bp_hs_once", hs_cnt - hs_base, 32'd1);
        check("bp_idle", {31'd0, tx_valid_o}, 32'd0);

        // Round-robin burst from ptr=0
        do_reset();
        tx_ready_i  = 1'b1;
        req_data_i  = 32'h13_00_11_10;
        req_pulse_i = 4'b1011;
        tick();
        req_pulse_i = 4'b0000;
        expect_tx("rr1_a", 8'h10, 4'b0001);
        expect_tx("rr1_b", 8'h11, 4'b0010);
        expect_tx("rr1_c", 8'h13, 4'b1000);
        req_pulse_i = 4'b1001;
        tick();
        req_pulse_i = 4'b0000;
        expect_tx("rr2_a", 8'h10, 4'b0001);
        expect_tx("rr2_b", 8'h13, 4'b1000);
        // Serve req 0 alone, then 0 and 3 together: order reveals the policy
        req_pulse_i = 4'b0001;
        tick();
        req_pulse_i = 4'b0000;
        expect_tx("rr3_solo", 8'h10, 4'b0001);
        req_pulse_i = 4'b1001;
        tick();
        req_pulse_i = 4'b0000;
`ifdef UART_ARB_FIXED_PRIO_EN
        expect_tx("rr3_a", 8'h10, 4'b0001);
        expect_tx("rr3_b", 8'h13, 4'b1000);
`else
        expect_tx("rr3_a", 8'h13, 4'b1000);
        expect_tx("rr3_b", 8'h10, 4'b0001);
`endif

        // Overflow on req 1 while req 0 is held in SEND
        tx_ready_i      = 1'b0;
        req_data_i      = 32'd0;
        req_data_i[7:0] = 8'h55;
        req_pulse_i     = 4'b0001;
        tick();
        req_pulse_i = 4'b0000;
        tick();
        req_data_i[15:8] = 8'h22;
        req_pulse_i      = 4'b0010;
        tick();
        req_data_i[15:8] = 8'h33;
        tick();
        req_pulse_i = 4'b0000;
        check("ovf_flag", {28'd0, overflow_o}, 32'h2);
        check("ovf_pending", {28'd0, pending_o}, 32'h3);
        tx_ready_i = 1'b1;
        tick();
        expect_tx("ovf_send", 8'h22, 4'b0010);
        ovf_clr_i = 1'b1;
        tick();
        ovf_clr_i = 1'b0;
        check("ovf_clr", {28'd0, overflow_o}, 32'd0);

        // Overflow set wins over a simultaneous clear
        tx_ready_i        = 1'b0;
        req_data_i[23:16] = 8'h41;
        req_pulse_i       = 4'b0100;
        tick();
        req_pulse_i = 4'b0000;
        tick();
        req_pulse_i = 4'b0100;
        ovf_clr_i   = 1'b1;
        tick();
        req_pulse_i = 4'b0000;
        ovf_clr_i   = 1'b0;
        check("ovf_setwins", {28'd0, overflow_o}, 32'h4);
        tx_ready_i = 1'b1;
        tick();
        ovf_clr_i = 1'b1;
        tick();
        ovf_clr_i = 1'b0;

        // Pulse on req 0 in its own handshake cycle
        tx_ready_i      = 1'b0;
        req_data_i[7:0] = 8'h66;
        req_pulse_i     = 4'b0001;
        tick();
        req_pulse_i = 4'b0000;
        tick();
        check("sim_first", {24'd0, tx_data_o}, 32'h66);
        tx_ready_i      = 1'b1;
        req_data_i[7:0] = 8'h77;
        req_pulse_i     = 4'b0001;
        tick();
        req_pulse_i = 4'b0000;
        check("sim_pending", {28'd0, pending_o}, 32'h1);
        check("sim_no_ovf", {28'd0, overflow_o}, 32'd0);
        expect_tx("sim_resend", 8'h77, 4'b0001);

        // Reset mid-SEND drops the held byte
        tx_ready_i       = 1'b0;
        req_data_i[15:8] = 8'h99;
        req_pulse_i      = 4'b0010;
        tick();
        req_pulse_i = 4'b0000;
        tick();
        check("rst_mid_valid_pre", {31'd0, tx_valid_o}, 32'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("rst_mid_valid", {31'd0, tx_valid_o}, 32'd0);
        check("rst_mid_data", {24'd0, tx_data_o}, 32'd0);
        check("rst_mid_grant", {28'd0, grant_o}, 32'd0);
        check("rst_mid_pending", {28'd0, pending_o}, 32'd0);
        check("rst_mid_overflow", {28'd0, overflow_o}, 32'd0);
        tx_ready_i = 1'b1;
        hs_base    = hs_cnt;
        for (int i = 0; i < 4; i++) tick();
        check("rst_mid_nosend", hs_cnt - hs_base, 32'd0);
        check("rst_mid_idle", {31'd0, tx_valid_o}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
